// File: rtl/stream_arb_2to1.sv
// Two-input valid/ready arbiter feeding a single registered output stage.
// It selects between A and B with round-robin or fixed priority, and accepts at most one beat per cycle.
module stream_arb_2to1 #(
    parameter int DATA_W = 8,
    parameter bit RR     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_valid,
    output logic              b_ready,
    output logic [DATA_W-1:0] y_data,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              y_sel
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]        state_reg, state_next;
    logic [DATA_W-1:0] y_data_reg, y_data_next;
    logic              y_sel_reg, y_sel_next;
    logic              prio_reg, prio_next;
    logic [DATA_W-1:0] mux_data;
    logic              load;
    logic              a_fire;
    logic              b_fire;

    // The register can take a new beat when it is empty or drains this cycle.
    assign load    = (state_reg == ST_EMPTY) | y_ready;
    assign a_ready = load & ~(b_valid & prio_reg);
    assign b_ready = load & ~(a_valid & ~prio_reg);
    assign a_fire  = a_valid & a_ready;
    assign b_fire  = b_valid & b_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_mux
            assign mux_data[gi] = b_fire ? b_data[gi] : a_data[gi];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        y_data_next = y_data_reg;
        y_sel_next  = y_sel_reg;
        if (load) begin
            if (a_fire | b_fire) begin
                state_next  = ST_FULL;
                y_data_next = mux_data;
                y_sel_next  = b_fire;
            end else begin
                state_next  = ST_EMPTY;
            end
        end
    end

    // The winner hands the turn to the other side; an idle cycle keeps the turn.
    generate
        if (RR) begin : g_rr
            always_comb begin
                prio_next = prio_reg;
                if (a_fire)
                    prio_next = 1'b1;
                else if (b_fire)
                    prio_next = 1'b0;
            end
        end else begin : g_fixed
            assign prio_next = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_EMPTY;
            y_data_reg <= '0;
            y_sel_reg  <= 1'b0;
            prio_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            y_data_reg <= y_data_next;
            y_sel_reg  <= y_sel_next;
            prio_reg   <= prio_next;
        end
    end

    assign y_valid = (state_reg == ST_FULL);
    assign y_data  = y_data_reg;
    assign y_sel   = y_sel_reg;

endmodule

// File: tb/tb_stream_arb_2to1.sv
// Scoreboard bench for stream_arb_2to1: one round-robin instance and one fixed-priority instance.
// Directed stimulus pushes the expected beats; negedge monitors pop and compare them on each output handshake.
module tb_stream_arb_2to1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_data, b_data, y_data;
    logic       a_valid, a_ready, b_valid, b_ready, y_valid, y_ready, y_sel;
    logic [7:0] fa_data, fb_data, fy_data;
    logic       fa_valid, fa_ready, fb_valid, fb_ready, fy_valid, fy_ready, fy_sel;

    logic [8:0] exp_q[$];
    logic [8:0] fexp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_arb_2to1 #(.DATA_W(8), .RR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .y_sel(y_sel)
    );

    stream_arb_2to1 #(.DATA_W(8), .RR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_data(fa_data), .a_valid(fa_valid), .a_ready(fa_ready),
        .b_data(fb_data), .b_valid(fb_valid), .b_ready(fb_ready),
        .y_data(fy_data), .y_valid(fy_valid), .y_ready(fy_ready), .y_sel(fy_sel)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
        fa_valid = 1'b0; fb_valid = 1'b0; fy_ready = 1'b1;
        repeat (n) step();
    endtask

    // Output monitors: one scoreboard pop per completed output handshake
    always @(negedge clk) begin
        if (rst_n && y_valid && y_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rr_beat: got sel=%0d data=%02h expected no beat", y_sel, y_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({y_sel, y_data} !== e) begin
                    n_fail++;
                    $display("FAIL rr_beat: got sel=%0d data=%02h expected sel=%0d data=%02h",
                             y_sel, y_data, e[8], e[7:0]);
                end else begin
                    $display("rr beat sel=%0d data=%02h ok", y_sel, y_data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && fy_valid && fy_ready) begin
            n_checks++;
            if (fexp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fp_beat: got sel=%0d data=%02h expected no beat", fy_sel, fy_data);
            end else begin
                logic [8:0] e;
                e = fexp_q.pop_front();
                if ({fy_sel, fy_data} !== e) begin
                    n_fail++;
                    $display("FAIL fp_beat: got sel=%0d data=%02h expected sel=%0d data=%02h",
                             fy_sel, fy_data, e[8], e[7:0]);
                end else begin
                    $display("fp beat sel=%0d data=%02h ok", fy_sel, fy_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_data = '0; b_data = '0; fa_data = '0; fb_data = '0;
        a_valid = 1'b0; b_valid = 1'b0; fa_valid = 1'b0; fb_valid = 1'b0;
        y_ready = 1'b1; fy_ready = 1'b1;

        // Reset held while both sources request: nothing may be captured
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h01; b_data = 8'h02;
        repeat (3) step();
        chk("rst_y_valid", 32'(y_valid), 0);
        chk("rst_y_data", 32'(y_data), 0);
        chk("rst_y_sel", 32'(y_sel), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_a_ready", 32'(a_ready), 1);
        chk("rel_b_ready", 32'(b_ready), 0);
        exp_q.push_back({1'b0, 8'h01});
        step();
        idle(2);

        // Single source A, back to back
        a_valid = 1'b1; b_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_data = 8'(8'h11 * (k + 1));
            #1;
            chk("single_a_ready", 32'(a_ready), 1);
            exp_q.push_back({1'b0, 8'(8'h11 * (k + 1))});
            step();
            if (k == 0) begin
                chk("latency_valid", 32'(y_valid), 1);
                chk("latency_data", 32'(y_data), 'h11);
            end
        end
        idle(2);

        // A lone B beat returns the turn to A, then full contention alternates
        b_valid = 1'b1; b_data = 8'h77;
        #1;
        chk("lone_b_ready", 32'(b_ready), 1);
        exp_q.push_back({1'b1, 8'h77});
        step();
        a_valid = 1'b1; b_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_data = 8'(8'hA0 + (k + 1) / 2);
            b_data = 8'(8'hB0 + k / 2);
            #1;
            chk("rr_a_ready", 32'(a_ready), (k % 2 == 0) ? 1 : 0);
            chk("rr_b_ready", 32'(b_ready), (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 0)
                exp_q.push_back({1'b0, 8'(8'hA0 + k / 2)});
            else
                exp_q.push_back({1'b1, 8'(8'hB0 + k / 2)});
            step();
        end
        idle(2);

        // Backpressure: held beat stays stable, readies drop
        y_ready = 1'b0; a_valid = 1'b1; a_data = 8'h5A; b_valid = 1'b0;
        #1;
        chk("bp_load_ready", 32'(a_ready), 1);
        exp_q.push_back({1'b0, 8'h5A});
        step();
        a_data = 8'h66; b_valid = 1'b1; b_data = 8'h99;
        repeat (4) begin
            #1;
            chk("bp_a_ready", 32'(a_ready), 0);
            chk("bp_b_ready", 32'(b_ready), 0);
            chk("bp_y_valid", 32'(y_valid), 1);
            chk("bp_y_data", 32'(y_data), 'h5A);
            step();
        end
        y_ready = 1'b1; a_data = 8'h6B; b_valid = 1'b0;
        #1;
        chk("drain_a_ready", 32'(a_ready), 1);
        exp_q.push_back({1'b0, 8'h6B});
        step();
        a_valid = 1'b0;
        #1;
        chk("no_bubble_valid", 32'(y_valid), 1);
        chk("no_bubble_data", 32'(y_data), 'h6B);
        idle(2);

        // Fixed priority: A always wins, B only once A goes idle
        fa_valid = 1'b1; fb_valid = 1'b1; fb_data = 8'hD1;
        for (int k = 0; k < 3; k++) begin
            fa_data = 8'(8'hC1 + k);
            #1;
            chk("fp_a_ready", 32'(fa_ready), 1);
            chk("fp_b_ready", 32'(fb_ready), 0);
            fexp_q.push_back({1'b0, 8'(8'hC1 + k)});
            step();
        end
        fa_valid = 1'b0;
        #1;
        chk("fp_b_served", 32'(fb_ready), 1);
        fexp_q.push_back({1'b1, 8'hD1});
        step();
        idle(2);

        // Asynchronous reset while a beat is held
        y_ready = 1'b0; a_valid = 1'b1; a_data = 8'h42;
        step();
        a_valid = 1'b0;
        #1;
        chk("held_before_rst", 32'(y_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(y_valid), 0);
        chk("async_rst_data", 32'(y_data), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        y_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h55; b_data = 8'h56;
        #1;
        chk("post_rst_a_ready", 32'(a_ready), 1);
        chk("post_rst_b_ready", 32'(b_ready), 0);
        exp_q.push_back({1'b0, 8'h55});
        step();
        a_valid = 1'b0;
        #1;
        chk("post_rst_b_turn", 32'(b_ready), 1);
        exp_q.push_back({1'b1, 8'h56});
        step();
        idle(3);

        for (int i = 0; i < 20 && (exp_q.size() + fexp_q.size()) > 0; i++)
            step();
        chk("rr_queue_empty", 32'(exp_q.size()), 0);
        chk("fp_queue_empty", 32'(fexp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
